// File: rtl/tmds_encoder.sv
// Single-channel TMDS 8b/10b encoder (DVI 1.0 algorithm) with running-disparity tracking.
// Two-stage pipeline: transition minimisation, then DC balancing / control token selection.
module tmds_encoder #(
    parameter logic [1:0] RESET_CTRL = 2'b00
) (
    input  logic       i_pixclk,
    input  logic       i_rstn,
    input  logic [7:0] i_data,
    input  logic       i_de,
    input  logic [1:0] i_ctrl,
    output logic [9:0] o_encoded_data,
    output logic       o_de
);

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // ---------------- stage 1: transition minimisation ----------------
    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] qm_next;
    logic [3:0] n1_next;

    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, i_data[i]};
        end
    end

    assign use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);

    always_comb begin
        qm_next    = '0;
        qm_next[0] = i_data[0];
        for (int i = 1; i < 8; i++) begin
            qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ i_data[i]) : (qm_next[i-1] ^ i_data[i]);
        end
        qm_next[8] = ~use_xnor;
    end

    always_comb begin
        n1_next = '0;
        for (int i = 0; i < 8; i++) begin
            n1_next = n1_next + {3'b000, qm_next[i]};
        end
    end

    logic       de_reg;
    logic [1:0] ctrl_reg;
    logic [8:0] qm_reg;
    logic [3:0] n1_reg;
    logic [3:0] n0_reg;

    always_ff @(posedge i_pixclk or negedge i_rstn) begin
        if (!i_rstn) begin
            de_reg   <= 1'b0;
            ctrl_reg <= RESET_CTRL;
            qm_reg   <= '0;
            n1_reg   <= '0;
            n0_reg   <= '0;
        end else begin
            de_reg   <= i_de;
            ctrl_reg <= i_ctrl;
            qm_reg   <= qm_next;
            n1_reg   <= n1_next;
            n0_reg   <= 4'd8 - n1_next;
        end
    end

    // ---------------- stage 2: DC balance ----------------
    // cnt_reg equals the running ones-minus-zeros of the symbols sent this active period.
    logic signed [4:0] cnt_reg;
    logic signed [4:0] cnt_next;
    logic signed [4:0] diff;
    logic        [9:0] sym_reg;
    logic        [9:0] sym_next;
    logic              de_out_reg;

    assign diff = $signed({1'b0, n1_reg}) - $signed({1'b0, n0_reg});

    always_comb begin
        sym_next = ctrl_token(ctrl_reg);
        cnt_next = '0;
        if (de_reg) begin
            if ((cnt_reg == 5'sd0) || (n1_reg == n0_reg)) begin
                sym_next = {~qm_reg[8], qm_reg[8], qm_reg[8] ? qm_reg[7:0] : ~qm_reg[7:0]};
                cnt_next = qm_reg[8] ? (cnt_reg + diff) : (cnt_reg - diff);
            end else if ((!cnt_reg[4] && (n1_reg > n0_reg)) || (cnt_reg[4] && (n0_reg > n1_reg))) begin
                // cnt_reg is known non-zero here, so a clear sign bit means positive
                sym_next = {1'b1, qm_reg[8], ~qm_reg[7:0]};
                cnt_next = cnt_reg + (qm_reg[8] ? 5'sd2 : 5'sd0) - diff;
            end else begin
                sym_next = {1'b0, qm_reg[8], qm_reg[7:0]};
                cnt_next = cnt_reg + diff - (qm_reg[8] ? 5'sd0 : 5'sd2);
            end
        end
    end

    always_ff @(posedge i_pixclk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_reg    <= '0;
            sym_reg    <= ctrl_token(RESET_CTRL);
            de_out_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            sym_reg    <= sym_next;
            de_out_reg <= de_reg;
        end
    end

    assign o_encoded_data = sym_reg;
    assign o_de           = de_out_reg;

endmodule
